axis_accumulate_reduce: RTL and testbench

//  Downstream reduction stage for elementwise-add kernels (e.g. multi-input add).

---
 rtl/axis_acc_pkg.sv | 58 +++++
 rtl/axis_accumulate_reduce.sv | 83 ++++++++
 tb/tb_axis_accumulate_reduce.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_acc_pkg.sv
// Shared helpers for the AXI-Stream accumulate/reduce stage: signedness mode and
// width-generic extend / saturating-add functions operating on MAX_W-bit containers.
package axis_acc_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } sign_mode_e;

    // Extends the low in_w bits of x to the full container, filling with the sign bit
    // in signed mode and with zeros otherwise.
    function automatic logic [MAX_W-1:0] ext_to_acc(
        input logic [MAX_W-1:0] x,
        input int               in_w,
        input sign_mode_e       mode
    );
        logic [MAX_W-1:0] low_mask;
        logic [MAX_W-1:0] sign_bit;
        logic             neg;
        low_mask = (in_w >= MAX_W) ? '1 : ((MAX_W'(1) << in_w) - MAX_W'(1));
        sign_bit = MAX_W'(1) << (in_w - 1);
        neg      = (mode == MODE_SIGNED) && ((x & sign_bit) != '0);
        return (x & low_mask) | (neg ? ~low_mask : '0);
    endfunction

    // Adds two acc_w-bit values one bit wider than the accumulator and clamps the
    // result into the representable range; callers keep the low acc_w bits.
    function automatic logic [MAX_W-1:0] sat_add(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int               acc_w,
        input sign_mode_e       mode
    );
        logic [MAX_W-1:0] sa, sb, sum, mask, sbit, carry;
        logic             a_neg, b_neg, s_neg;
        logic [MAX_W-1:0] r;
        sa    = ext_to_acc(a, acc_w, mode);
        sb    = ext_to_acc(b, acc_w, mode);
        sum   = sa + sb;
        mask  = (MAX_W'(1) << acc_w) - MAX_W'(1);
        sbit  = MAX_W'(1) << (acc_w - 1);
        carry = MAX_W'(1) << acc_w;
        a_neg = (sa & sbit) != '0;
        b_neg = (sb & sbit) != '0;
        s_neg = (sum & sbit) != '0;
        r     = sum;
        if (mode == MODE_UNSIGNED) begin
            if ((sum & carry) != '0) r = mask;
        end else begin
            if (!a_neg && !b_neg && s_neg)     r = mask >> 1;
            else if (a_neg && b_neg && !s_neg) r = sbit;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_accumulate_reduce.sv
// Sums each group of NUM_ITEMS input words into one ACC_WIDTH output word with a single
// registered output slot. Define ACC_SATURATE_EN to clamp instead of wrapping.
module axis_accumulate_reduce
    import axis_acc_pkg::*;
#(
    parameter int INPUT_WIDTH  = 8,
    parameter int SIGNED_INPUT = 0,
    parameter int ACC_WIDTH    = 16,
    parameter int NUM_ITEMS    = 4
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [INPUT_WIDTH-1:0] s_axis_input0_tdata,
    input  logic                   s_axis_input0_tvalid,
    output logic                   s_axis_input0_tready,
    output logic [ACC_WIDTH-1:0]   m_axis_output0_tdata,
    output logic                   m_axis_output0_tvalid,
    input  logic                   m_axis_output0_tready
);

    localparam int CNT_WIDTH = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_ITEMS - 1);
    localparam sign_mode_e MODE = (SIGNED_INPUT != 0) ? MODE_SIGNED : MODE_UNSIGNED;

    logic [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic [ACC_WIDTH-1:0] data_reg, data_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 valid_reg, valid_next;
    logic [ACC_WIDTH-1:0] ext_x;
    logic [ACC_WIDTH-1:0] sum;
    logic                 in_fire, out_fire, last_beat;

    assign last_beat             = (cnt_reg == LAST_CNT);
    // Only the closing beat of a group needs the output slot to be free.
    assign s_axis_input0_tready  = ~ap_rst & (~last_beat | ~valid_reg | m_axis_output0_tready);
    assign in_fire               = s_axis_input0_tvalid & s_axis_input0_tready;
    assign out_fire              = valid_reg & m_axis_output0_tready;
    assign m_axis_output0_tdata  = data_reg;
    assign m_axis_output0_tvalid = valid_reg;

    always_comb begin
        ext_x = ACC_WIDTH'(ext_to_acc(MAX_W'(s_axis_input0_tdata), INPUT_WIDTH, MODE));
`ifdef ACC_SATURATE_EN
        sum = ACC_WIDTH'(sat_add(MAX_W'(acc_reg), MAX_W'(ext_x), ACC_WIDTH, MODE));
`else
        sum = acc_reg + ext_x;
`endif
    end

    always_comb begin
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        if (out_fire) valid_next = 1'b0;
        if (in_fire) begin
            if (last_beat) begin
                data_next  = sum;
                valid_next = 1'b1;
                acc_next   = '0;
                cnt_next   = '0;
            end else begin
                acc_next = sum;
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

endmodule

// File: tb/tb_axis_accumulate_reduce.sv
// Directed bench for axis_accumulate_reduce: several parameterisations share one input
// stream; expectations for the 8-bit accumulators depend on ACC_SATURATE_EN.
module tb_axis_accumulate_reduce;

    logic        ap_clk;
    logic        ap_rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        n1_tvalid;
    logic        m_tready;

    logic        u_tready, s_tready, u8_tready, s8_tready, n1_tready;
    logic [15:0] u_tdata, s_odata, n1_tdata;
    logic [7:0]  u8_tdata, s8_tdata;
    logic        u_tvalid, s_ovalid, u8_tvalid, s8_tvalid, n1_ovalid;

    int errors = 0;
    int checks = 0;

    axis_accumulate_reduce #(.INPUT_WIDTH(8), .SIGNED_INPUT(0), .ACC_WIDTH(16), .NUM_ITEMS(4)) dut_u (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_input0_tdata(s_tdata), .s_axis_input0_tvalid(s_tvalid), .s_axis_input0_tready(u_tready),
        .m_axis_output0_tdata(u_tdata), .m_axis_output0_tvalid(u_tvalid), .m_axis_output0_tready(m_tready));

    axis_accumulate_reduce #(.INPUT_WIDTH(8), .SIGNED_INPUT(1), .ACC_WIDTH(16), .NUM_ITEMS(4)) dut_s (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_input0_tdata(s_tdata), .s_axis_input0_tvalid(s_tvalid), .s_axis_input0_tready(s_tready),
        .m_axis_output0_tdata(s_odata), .m_axis_output0_tvalid(s_ovalid), .m_axis_output0_tready(m_tready));

    axis_accumulate_reduce #(.INPUT_WIDTH(8), .SIGNED_INPUT(0), .ACC_WIDTH(8), .NUM_ITEMS(4)) dut_u8 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_input0_tdata(s_tdata), .s_axis_input0_tvalid(s_tvalid), .s_axis_input0_tready(u8_tready),
        .m_axis_output0_tdata(u8_tdata), .m_axis_output0_tvalid(u8_tvalid), .m_axis_output0_tready(m_tready));

    axis_accumulate_reduce #(.INPUT_WIDTH(8), .SIGNED_INPUT(1), .ACC_WIDTH(8), .NUM_ITEMS(4)) dut_s8 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_input0_tdata(s_tdata), .s_axis_input0_tvalid(s_tvalid), .s_axis_input0_tready(s8_tready),
        .m_axis_output0_tdata(s8_tdata), .m_axis_output0_tvalid(s8_tvalid), .m_axis_output0_tready(m_tready));

    axis_accumulate_reduce #(.INPUT_WIDTH(8), .SIGNED_INPUT(0), .ACC_WIDTH(16), .NUM_ITEMS(1)) dut_n1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_input0_tdata(s_tdata), .s_axis_input0_tvalid(n1_tvalid), .s_axis_input0_tready(n1_tready),
        .m_axis_output0_tdata(n1_tdata), .m_axis_output0_tvalid(n1_ovalid), .m_axis_output0_tready(m_tready));

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Presents one word to the shared stream and holds it until accepted (bounded).
    task automatic send_beat(input logic [7:0] d);
        int k;
        s_tdata  = d;
        s_tvalid = 1'b1;
        #1;
        k = 0;
        while (!u_tready && k < 20) begin
            step();
            k++;
        end
        checks++;
        if (u_tready !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept data=%0h tready=%b required 1", d, u_tready);
        end
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst    = 1'b1;
        s_tvalid  = 1'b0;
        n1_tvalid = 1'b0;
        m_tready  = 1'b1;
        s_tdata   = 8'h00;
        step();
        step();
        checks++;
        if (u_tvalid !== 1'b0 || u_tdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out valid=%b data=%h required 0/0000", u_tvalid, u_tdata);
        end
        checks++;
        if (u_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready got=%b required 0", u_tready);
        end
        ap_rst = 1'b0;
        #1;
        checks++;
        if (u_tready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_tready got=%b required 1", u_tready);
        end
        step();
        $display("reset done");
    endtask

    task automatic test_unsigned_sum();
        m_tready = 1'b1;
        send_beat(8'd1);
        send_beat(8'd2);
        send_beat(8'd3);
        checks++;
        if (u_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid got=%b required 0", u_tvalid);
        end
        send_beat(8'd4);
        checks++;
        if (u_tvalid !== 1'b1 || u_tdata !== 16'd10) begin
            errors++;
            $display("FAIL unsigned_sum valid=%b data=%0d required 1/10", u_tvalid, u_tdata);
        end
        $display("unsigned group out=%0d", u_tdata);
        step();
        checks++;
        if (u_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL drain_valid got=%b required 0", u_tvalid);
        end
    endtask

    task automatic test_signed_sum();
        m_tready = 1'b1;
        repeat (4) send_beat(8'hFF);
        checks++;
        if (s_ovalid !== 1'b1 || s_odata !== 16'hFFFC) begin
            errors++;
            $display("FAIL signed_neg valid=%b data=%h required 1/fffc", s_ovalid, s_odata);
        end
        checks++;
        if (u_tdata !== 16'h03FC) begin
            errors++;
            $display("FAIL unsigned_ff data=%h required 03fc", u_tdata);
        end
        $display("signed group out=%h unsigned out=%h", s_odata, u_tdata);
        send_beat(8'h80);
        send_beat(8'h7F);
        send_beat(8'h01);
        send_beat(8'h00);
        checks++;
        if (s_ovalid !== 1'b1 || s_odata !== 16'h0000) begin
            errors++;
            $display("FAIL signed_zero valid=%b data=%h required 1/0000", s_ovalid, s_odata);
        end
        $display("signed group out=%h", s_odata);
        step();
    endtask

    task automatic test_backpressure();
        m_tready = 1'b1;
        send_beat(8'd1);
        send_beat(8'd2);
        send_beat(8'd3);
        send_beat(8'd4);
        m_tready = 1'b0;
        repeat (3) begin
            send_beat(8'd5);
            checks++;
            if (u_tvalid !== 1'b1 || u_tdata !== 16'd10) begin
                errors++;
                $display("FAIL bp_hold valid=%b data=%0d required 1/10", u_tvalid, u_tdata);
            end
        end
        s_tdata  = 8'd5;
        s_tvalid = 1'b1;
        #1;
        checks++;
        if (u_tready !== 1'b0) begin
            errors++;
            $display("FAIL bp_final_tready got=%b required 0", u_tready);
        end
        step();
        step();
        checks++;
        if (u_tready !== 1'b0 || u_tvalid !== 1'b1 || u_tdata !== 16'd10) begin
            errors++;
            $display("FAIL bp_stall tready=%b valid=%b data=%0d required 0/1/10", u_tready, u_tvalid, u_tdata);
        end
        m_tready = 1'b1;
        #1;
        checks++;
        if (u_tready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_tready got=%b required 1", u_tready);
        end
        step();
        s_tvalid = 1'b0;
        checks++;
        if (u_tvalid !== 1'b1 || u_tdata !== 16'd20) begin
            errors++;
            $display("FAIL bp_second valid=%b data=%0d required 1/20", u_tvalid, u_tdata);
        end
        $display("backpressure group out=%0d", u_tdata);
        step();
        checks++;
        if (u_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain valid=%b required 0", u_tvalid);
        end
    endtask

    task automatic test_wrap_saturate();
        logic [7:0] exp_u8;
        logic [7:0] exp_s8;
`ifdef ACC_SATURATE_EN
        exp_u8 = 8'd255;
        exp_s8 = 8'h7F;
`else
        exp_u8 = 8'd44;
        exp_s8 = 8'hFE;
`endif
        m_tready = 1'b1;
        send_beat(8'd200);
        send_beat(8'd100);
        send_beat(8'd0);
        send_beat(8'd0);
        checks++;
        if (u8_tvalid !== 1'b1 || u8_tdata !== exp_u8) begin
            errors++;
            $display("FAIL u8_overflow valid=%b data=%0d required 1/%0d", u8_tvalid, u8_tdata, exp_u8);
        end
        checks++;
        if (u_tdata !== 16'd300) begin
            errors++;
            $display("FAIL u16_no_overflow data=%0d required 300", u_tdata);
        end
        $display("overflow group u8=%0d u16=%0d", u8_tdata, u_tdata);
        send_beat(8'h7F);
        send_beat(8'h7F);
        send_beat(8'h00);
        send_beat(8'h00);
        checks++;
        if (s8_tvalid !== 1'b1 || s8_tdata !== exp_s8) begin
            errors++;
            $display("FAIL s8_overflow valid=%b data=%h required 1/%h", s8_tvalid, s8_tdata, exp_s8);
        end
        checks++;
        if (u8_tdata !== 8'hFE) begin
            errors++;
            $display("FAIL u8_fe data=%h required fe", u8_tdata);
        end
        $display("overflow group s8=%h u8=%h", s8_tdata, u8_tdata);
        step();
    endtask

    task automatic test_reset_mid_group();
        m_tready = 1'b1;
        send_beat(8'd9);
        send_beat(8'd9);
        ap_rst = 1'b1;
        #1;
        checks++;
        if (u_tready !== 1'b0 || u_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_during tready=%b valid=%b required 0/0", u_tready, u_tvalid);
        end
        step();
        ap_rst = 1'b0;
        checks++;
        if (u_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after valid=%b required 0", u_tvalid);
        end
        repeat (4) send_beat(8'd1);
        checks++;
        if (u_tvalid !== 1'b1 || u_tdata !== 16'd4) begin
            errors++;
            $display("FAIL midrst_sum valid=%b data=%0d required 1/4", u_tvalid, u_tdata);
        end
        $display("post-reset group out=%0d", u_tdata);
        step();
    endtask

    task automatic test_back_to_back();
        bit exp_v;
        m_tready = 1'b1;
        s_tdata  = 8'd3;
        s_tvalid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            checks++;
            if (u_tready !== 1'b1) begin
                errors++;
                $display("FAIL stream_tready beat=%0d got=%b required 1", i, u_tready);
            end
            step();
            exp_v = (i % 4 == 0);
            checks++;
            if (u_tvalid !== exp_v || (exp_v && u_tdata !== 16'd12)) begin
                errors++;
                $display("FAIL stream_out beat=%0d valid=%b data=%0d required %b/12", i, u_tvalid, u_tdata, exp_v);
            end
            if (exp_v) $display("stream group out=%0d at beat %0d", u_tdata, i);
        end
        s_tvalid = 1'b0;
        step();
    endtask

    task automatic test_single_item();
        m_tready  = 1'b1;
        n1_tvalid = 1'b1;
        s_tdata   = 8'h85;
        #1;
        checks++;
        if (n1_tready !== 1'b1) begin
            errors++;
            $display("FAIL n1_tready got=%b required 1", n1_tready);
        end
        step();
        checks++;
        if (n1_ovalid !== 1'b1 || n1_tdata !== 16'h0085) begin
            errors++;
            $display("FAIL n1_first valid=%b data=%h required 1/0085", n1_ovalid, n1_tdata);
        end
        s_tdata = 8'h07;
        step();
        checks++;
        if (n1_ovalid !== 1'b1 || n1_tdata !== 16'h0007) begin
            errors++;
            $display("FAIL n1_second valid=%b data=%h required 1/0007", n1_ovalid, n1_tdata);
        end
        m_tready = 1'b0;
        s_tdata  = 8'h10;
        #1;
        step();
        checks++;
        if (n1_tready !== 1'b0 || n1_tdata !== 16'h0007) begin
            errors++;
            $display("FAIL n1_stall tready=%b data=%h required 0/0007", n1_tready, n1_tdata);
        end
        m_tready = 1'b1;
        step();
        checks++;
        if (n1_ovalid !== 1'b1 || n1_tdata !== 16'h0010) begin
            errors++;
            $display("FAIL n1_release valid=%b data=%h required 1/0010", n1_ovalid, n1_tdata);
        end
        $display("single-item out=%h", n1_tdata);
        n1_tvalid = 1'b0;
        step();
        checks++;
        if (n1_ovalid !== 1'b0) begin
            errors++;
            $display("FAIL n1_drain valid=%b required 0", n1_ovalid);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_sum();
        test_signed_sum();
        test_backpressure();
        test_wrap_saturate();
        test_reset_mid_group();
        test_back_to_back();
        test_single_item();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
